adc_rectifier_v3: RTL and testbench

//  Multi-channel, pipelined rectifier for the ADC sample path; successor of the single-channel

---
 rtl/adc_rectifier_v3.sv | 171 +++++++++++++++++
 tb/tb_adc_rectifier_v3.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_rectifier_v3.sv
// Multi-channel pipelined rectifier: per-lane mode select, most-negative-code saturation
// with sticky flags, and a windowed signed peak detector on the rectified stream.
module adc_rectifier_v3 #(
   parameter int DATA_W = 16,
   parameter int N_CH   = 2,
   parameter int HOLD_W = 24
) (
   input  logic                   adc_clk_i,
   input  logic                   adc_rstn_i,
   input  logic [N_CH*DATA_W-1:0] adc_data_i,
   input  logic                   adc_valid_i,
   input  logic [1:0]             mode_i,
   input  logic [HOLD_W-1:0]      hold_len_i,
   input  logic                   sat_clr_i,
   output logic [N_CH*DATA_W-1:0] adc_data_o,
   output logic                   adc_valid_o,
   output logic [N_CH*DATA_W-1:0] peak_o,
   output logic                   peak_valid_o,
   output logic [N_CH-1:0]        sat_o
);

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_ABS  = 2'b01,
      MODE_HPOS = 2'b10,
      MODE_HNEG = 2'b11
   } mode_t;

   localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};

   // Returns {saturated, y}; only |MIN| can saturate.
   function automatic logic [DATA_W:0] rectify(input logic [DATA_W-1:0] x, input mode_t m);
      logic              neg;
      logic              is_min;
      logic [DATA_W-1:0] mag;
      logic [DATA_W-1:0] y;
      logic              sat;
      neg    = x[DATA_W-1];
      is_min = (x == SMIN);
      mag    = is_min ? SMAX : (neg ? (~x + 1'b1) : x);
      y      = '0;
      sat    = 1'b0;
      case (m)
         MODE_PASS: y = x;
         MODE_ABS: begin
            y   = mag;
            sat = is_min;
         end
         MODE_HPOS: y = neg ? '0 : x;
         MODE_HNEG: begin
            y   = neg ? mag : '0;
            sat = is_min;
         end
         default: y = x;
      endcase
      return {sat, y};
   endfunction

   // Stage 1: sample, qualifier and mode travel together
   logic                   s1_valid_reg;
   logic [N_CH*DATA_W-1:0] s1_data_reg;
   mode_t                  s1_mode_reg;

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
         s1_mode_reg  <= MODE_PASS;
      end else begin
         s1_valid_reg <= adc_valid_i;
         if (adc_valid_i) begin
            s1_data_reg <= adc_data_i;
            s1_mode_reg <= mode_t'(mode_i);
         end
      end
   end

   // Stage 2: per-lane rectification
   logic [N_CH*DATA_W-1:0] y_next;
   logic [N_CH-1:0]        sat_hit;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
         logic [DATA_W:0] r;
         assign r                            = rectify(s1_data_reg[gi*DATA_W +: DATA_W], s1_mode_reg);
         assign y_next[gi*DATA_W +: DATA_W]  = r[DATA_W-1:0];
         assign sat_hit[gi]                  = r[DATA_W];
      end
   endgenerate

   logic [N_CH*DATA_W-1:0] data_o_reg;
   logic                   valid_o_reg;
   logic [N_CH-1:0]        sat_reg;

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         data_o_reg  <= '0;
         valid_o_reg <= 1'b0;
         sat_reg     <= '0;
      end else begin
         valid_o_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            data_o_reg <= y_next;
         end
         // set wins over a simultaneous clear
         sat_reg <= (sat_hit & {N_CH{s1_valid_reg}}) | (sat_reg & ~{N_CH{sat_clr_i}});
      end
   end

   assign adc_data_o  = data_o_reg;
   assign adc_valid_o = valid_o_reg;
   assign sat_o       = sat_reg;

   // Peak window, driven by the output stream
   logic [HOLD_W-1:0]      cnt_reg;
   logic [HOLD_W-1:0]      len_reg;
   logic [N_CH*DATA_W-1:0] run_reg;
   logic [N_CH*DATA_W-1:0] peak_reg;
   logic                   peak_valid_reg;

   logic                   win_first;
   logic [HOLD_W-1:0]      cur_len;
   logic                   win_last;
   logic [N_CH*DATA_W-1:0] run_next;

   always_comb begin
      win_first = (cnt_reg == '0);
      cur_len   = len_reg;
      if (win_first) begin
         cur_len = (hold_len_i == '0) ? HOLD_W'(1) : hold_len_i;
      end
      win_last = (cnt_reg == (cur_len - HOLD_W'(1)));
      run_next = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (win_first ||
             ($signed(data_o_reg[ch*DATA_W +: DATA_W]) > $signed(run_reg[ch*DATA_W +: DATA_W]))) begin
            run_next[ch*DATA_W +: DATA_W] = data_o_reg[ch*DATA_W +: DATA_W];
         end else begin
            run_next[ch*DATA_W +: DATA_W] = run_reg[ch*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         cnt_reg        <= '0;
         len_reg        <= '0;
         run_reg        <= '0;
         peak_reg       <= '0;
         peak_valid_reg <= 1'b0;
      end else begin
         peak_valid_reg <= 1'b0;
         if (valid_o_reg) begin
            if (win_last) begin
               cnt_reg        <= '0;
               peak_reg       <= run_next;
               peak_valid_reg <= 1'b1;
            end else begin
               cnt_reg <= cnt_reg + HOLD_W'(1);
               len_reg <= cur_len;
               run_reg <= run_next;
            end
         end
      end
   end

   assign peak_o       = peak_reg;
   assign peak_valid_o = peak_valid_reg;

endmodule

// File: tb/tb_adc_rectifier_v3.sv
// Directed bench for adc_rectifier_v3 with four lanes of 16-bit samples.
module tb_adc_rectifier_v3;

   localparam int DW = 16;
   localparam int NC = 4;
   localparam int HW = 24;

   logic            clk = 1'b0;
   logic            rstn;
   logic [NC*DW-1:0] din;
   logic            vin;
   logic [1:0]      mode;
   logic [HW-1:0]   hold;
   logic            clr;
   logic [NC*DW-1:0] dout;
   logic            vout;
   logic [NC*DW-1:0] peak;
   logic            pv;
   logic [NC-1:0]   sat;

   int n_tests = 0;
   int n_fail  = 0;

   adc_rectifier_v3 #(.DATA_W(DW), .N_CH(NC), .HOLD_W(HW)) dut (
      .adc_clk_i   (clk),
      .adc_rstn_i  (rstn),
      .adc_data_i  (din),
      .adc_valid_i (vin),
      .mode_i      (mode),
      .hold_len_i  (hold),
      .sat_clr_i   (clr),
      .adc_data_o  (dout),
      .adc_valid_o (vout),
      .peak_o      (peak),
      .peak_valid_o(pv),
      .sat_o       (sat)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pk4(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %h", tag, got);
      end
   endtask

   // One valid sample; returns at the negedge where it is on the output, plus the
   // following negedge's peak status.
   task automatic push(input logic [63:0] d, input logic [1:0] m, input logic c,
                       output logic [63:0] y, output logic v, output logic p, output logic [63:0] pk);
      din  = d;
      vin  = 1'b1;
      mode = m;
      @(negedge clk);
      vin = 1'b0;
      clr = c;
      @(negedge clk);
      clr = 1'b0;
      y   = dout;
      v   = vout;
      @(negedge clk);
      p   = pv;
      pk  = peak;
   endtask

   logic [63:0] y, pkv;
   logic        v, p;
   logic [63:0] bx [4];
   logic [63:0] be [4];

   initial begin
      rstn = 1'b0;
      din  = '0;
      vin  = 1'b0;
      mode = 2'b00;
      hold = 24'd4;
      clr  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_data", dout, 64'h0);
      check("rst_valid", {63'h0, vout}, 64'h0);
      check("rst_peak", peak, 64'h0);
      check("rst_pv", {63'h0, pv}, 64'h0);
      check("rst_sat", {60'h0, sat}, 64'h0);
      rstn = 1'b1;
      @(negedge clk);

      // window of 4, hold changed mid-window must not matter
      push(pk4(5, -1, 100, 7), 2'b00, 1'b0, y, v, p, pkv);
      check("pk_s1_data", y, pk4(5, -1, 100, 7));
      check("pk_s1_valid", {63'h0, v}, 64'h1);
      check("pk_s1_pv", {63'h0, p}, 64'h0);
      hold = 24'd2;
      push(pk4(-3, -2, 200, 7), 2'b00, 1'b0, y, v, p, pkv);
      check("pk_s2_pv", {63'h0, p}, 64'h0);
      push(pk4(9, -3, 50, 8), 2'b00, 1'b0, y, v, p, pkv);
      check("pk_s3_pv", {63'h0, p}, 64'h0);
      push(pk4(2, -4, -300, -9), 2'b00, 1'b0, y, v, p, pkv);
      check("pk_s4_pv", {63'h0, p}, 64'h1);
      check("pk_s4_peak", pkv, pk4(9, -1, 200, 8));
      hold = 24'd0;
      @(negedge clk);
      check("pk_pulse_len", {63'h0, pv}, 64'h0);

      // hold 0 behaves as 1: every sample is its own peak
      push(pk4(-4, 11, 0, 32767), 2'b00, 1'b0, y, v, p, pkv);
      check("h0_a_pv", {63'h0, p}, 64'h1);
      check("h0_a_peak", pkv, pk4(-4, 11, 0, 32767));
      push(pk4(3, -20, -1, 1), 2'b00, 1'b0, y, v, p, pkv);
      check("h0_b_pv", {63'h0, p}, 64'h1);
      check("h0_b_peak", pkv, pk4(3, -20, -1, 1));

      // back-to-back samples, mode changes each sample
      for (int i = 0; i < 4; i++) bx[i] = pk4(-1000, 300, -5, 0);
      be[0] = pk4(-1000, 300, -5, 0);
      be[1] = pk4(1000, 300, 5, 0);
      be[2] = pk4(0, 300, 0, 0);
      be[3] = pk4(1000, 0, 5, 0);
      for (int i = 0; i < 6; i++) begin
         if (i >= 2) begin
            check($sformatf("mode%0d_data", i - 2), dout, be[i-2]);
            check($sformatf("mode%0d_valid", i - 2), {63'h0, vout}, 64'h1);
         end
         if (i < 4) begin
            din  = bx[i];
            vin  = 1'b1;
            mode = 2'(i);
         end else begin
            vin = 1'b0;
         end
         @(negedge clk);
      end
      check("bubble_valid", {63'h0, vout}, 64'h0);
      check("bubble_hold", dout, be[3]);
      check("mode_nosat", {60'h0, sat}, 64'h0);

      // window of 3 with gaps and a mode switch between samples
      hold = 24'd3;
      push(pk4(-50, 1, -1, 0), 2'b00, 1'b0, y, v, p, pkv);
      check("gap_a_pv", {63'h0, p}, 64'h0);
      repeat (3) @(negedge clk);
      push(pk4(-60, -2, -100, 0), 2'b01, 1'b0, y, v, p, pkv);
      check("gap_b_data", y, pk4(60, 2, 100, 0));
      check("gap_b_pv", {63'h0, p}, 64'h0);
      repeat (2) @(negedge clk);
      push(pk4(10, 3, -2, 0), 2'b00, 1'b0, y, v, p, pkv);
      check("gap_c_data", y, pk4(10, 3, -2, 0));
      check("gap_c_pv", {63'h0, p}, 64'h1);
      check("gap_c_peak", pkv, pk4(60, 3, 100, 0));

      // saturation, set-over-clear, clear alone
      push(pk4(-32768, 5, -7, -32768), 2'b01, 1'b0, y, v, p, pkv);
      check("sat_data", y, pk4(32767, 5, 7, 32767));
      check("sat_flags", {60'h0, sat}, 64'h9);
      push(pk4(-32768, 0, 0, 0), 2'b01, 1'b1, y, v, p, pkv);
      check("sat_setclr_data", y, pk4(32767, 0, 0, 0));
      check("sat_setclr", {60'h0, sat}, 64'h1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("sat_clear", {60'h0, sat}, 64'h0);
      push(pk4(3, 3, -32768, 3), 2'b11, 1'b0, y, v, p, pkv);
      check("sat_hneg_data", y, pk4(0, 0, 32767, 0));
      check("sat_hneg", {60'h0, sat}, 64'h4);

      // asynchronous reset mid-stream, mid-window
      din  = pk4(1, 1, 1, 1);
      vin  = 1'b1;
      mode = 2'b00;
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("arst_data", dout, 64'h0);
      check("arst_valid", {63'h0, vout}, 64'h0);
      check("arst_peak", peak, 64'h0);
      check("arst_pv", {63'h0, pv}, 64'h0);
      check("arst_sat", {60'h0, sat}, 64'h0);
      @(negedge clk);
      vin  = 1'b0;
      rstn = 1'b1;
      @(negedge clk);

      // partial window discarded: fresh window of 3 after reset
      push(pk4(1, -1, 2, -2), 2'b00, 1'b0, y, v, p, pkv);
      check("post_a_pv", {63'h0, p}, 64'h0);
      push(pk4(4, -4, 1, -1), 2'b00, 1'b0, y, v, p, pkv);
      check("post_b_pv", {63'h0, p}, 64'h0);
      push(pk4(2, -3, 3, -5), 2'b00, 1'b0, y, v, p, pkv);
      check("post_c_pv", {63'h0, p}, 64'h1);
      check("post_c_peak", pkv, pk4(4, -1, 3, -1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
